// File: rtl/completion_arbiter.sv
// completion_arbiter
//   Merges results from four functional units onto one completion bus.
//   Each unit has a private 2-entry FIFO of {tag, value}; a round-robin
//   arbiter pops one FIFO head per beat into a registered output stage
//   that honours completionReady_i backpressure.
//
// Ports
//   clk_i                 single clock, rising edge
//   reset_i               asynchronous, active-low reset
//   flush_i               synchronous flush (branch mispredict)
//   fuValid_i[3:0]        unit i presents a result
//   fuTag_i[i]            ROB tag of unit i's result (0 = illegal)
//   fuVal_i[i]            65-bit result, bit 64 = flag
//   fuReady_o[3:0]        unit i's FIFO has room (registered count < 2)
//   completionReady_i     downstream accepts the current beat
//   completionValid_o     beat valid
//   completionRSROBTag_o  broadcast tag (0 when not valid)
//   completionRSROBval_o  broadcast value (0 when not valid)
//   badTag_o              sticky: a push with tag 0 was seen
//   busy_o                any FIFO non-empty or a beat is pending
module completion_arbiter #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [3:0]                 fuValid_i,
    input  logic [3:0][ROBsizeLog-1:0] fuTag_i,
    input  logic [3:0][64:0]           fuVal_i,
    output logic [3:0]                 fuReady_o,
    input  logic                       completionReady_i,
    output logic                       completionValid_o,
    output logic [ROBsizeLog-1:0]      completionRSROBTag_o,
    output logic [64:0]                completionRSROBval_o,
    output logic                       badTag_o,
    output logic                       busy_o
);

    // Per-unit FIFO: entry 0 is always the head.
    logic [1:0]            cnt_q [4];
    logic [ROBsizeLog-1:0] tag_q [4][2];
    logic [64:0]           val_q [4][2];

    logic [1:0]            rr_q;
    logic                  out_vld_q;
    logic [ROBsizeLog-1:0] out_tag_q;
    logic [64:0]           out_val_q;
    logic                  bad_tag_q;

    logic [3:0] push;
    logic [3:0] zero_tag;
    logic [3:0] pop;
    logic [3:0] wr_sel;
    logic       advance;
    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       any_cnt;

    always_comb begin
        any_cnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fuReady_o[i] = (cnt_q[i] < 2'd2);
            push[i]      = fuValid_i[i] & fuReady_o[i] & ~flush_i & (fuTag_i[i] != '0);
            zero_tag[i]  = fuValid_i[i] & fuReady_o[i] & ~flush_i & (fuTag_i[i] == '0);
            any_cnt      = any_cnt | (cnt_q[i] != 2'd0);
        end
    end

    assign advance = ~out_vld_q | completionReady_i;

    // Round-robin search starting at rr_q over the registered counts, so a
    // push is only visible to arbitration from the following edge.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_q;
        cand    = rr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_q + 2'(k);
            if (!win_vld && (cnt_q[cand] != 2'd0)) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pop[i]    = advance & win_vld & (win_idx == 2'(i)) & ~flush_i;
            // Push lands behind whatever remains after a same-edge pop.
            wr_sel[i] = (cnt_q[i] != 2'd0) & ~pop[i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= 2'd0;
            rr_q      <= 2'd0;
            out_vld_q <= 1'b0;
            out_tag_q <= '0;
            out_val_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= 2'd0;
            rr_q      <= 2'd0;
            out_vld_q <= 1'b0;
            out_tag_q <= '0;
            out_val_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i] && !pop[i])
                    cnt_q[i] <= cnt_q[i] + 2'd1;
                else if (pop[i] && !push[i])
                    cnt_q[i] <= cnt_q[i] - 2'd1;
            end
            if (advance) begin
                if (win_vld) begin
                    out_vld_q <= 1'b1;
                    out_tag_q <= tag_q[win_idx][0];
                    out_val_q <= val_q[win_idx][0];
                    rr_q      <= win_idx + 2'd1;
                end else begin
                    out_vld_q <= 1'b0;
                    out_tag_q <= '0;
                    out_val_q <= '0;
                end
            end
        end
    end

    // Sticky error survives flush; only reset clears it.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            bad_tag_q <= 1'b0;
        else if (|zero_tag)
            bad_tag_q <= 1'b1;
    end

    // FIFO payload storage; validity is tracked entirely by cnt_q.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                tag_q[i][0] <= tag_q[i][1];
                val_q[i][0] <= val_q[i][1];
            end
            if (push[i]) begin
                tag_q[i][wr_sel[i]] <= fuTag_i[i];
                val_q[i][wr_sel[i]] <= fuVal_i[i];
            end
        end
    end

    assign completionValid_o    = out_vld_q;
    assign completionRSROBTag_o = out_tag_q;
    assign completionRSROBval_o = out_val_q;
    assign badTag_o             = bad_tag_q;
    assign busy_o               = out_vld_q | any_cnt;

endmodule

// File: tb/tb_completion_arbiter.sv
module tb_completion_arbiter;

    localparam int TW = 6;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             flush_i;
    logic [3:0]       fuValid_i;
    logic [3:0][TW-1:0] fuTag_i;
    logic [3:0][64:0] fuVal_i;
    logic [3:0]       fuReady_o;
    logic             completionReady_i;
    logic             completionValid_o;
    logic [TW-1:0]    completionRSROBTag_o;
    logic [64:0]      completionRSROBval_o;
    logic             badTag_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    completion_arbiter dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .flush_i              (flush_i),
        .fuValid_i            (fuValid_i),
        .fuTag_i              (fuTag_i),
        .fuVal_i              (fuVal_i),
        .fuReady_o            (fuReady_o),
        .completionReady_i    (completionReady_i),
        .completionValid_o    (completionValid_o),
        .completionRSROBTag_o (completionRSROBTag_o),
        .completionRSROBval_o (completionRSROBval_o),
        .badTag_o             (badTag_o),
        .busy_o               (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_push(input int u, input logic [TW-1:0] tag, input logic [64:0] val);
        fuValid_i[u] = 1'b1;
        fuTag_i[u]   = tag;
        fuVal_i[u]   = val;
    endtask

    task automatic clear_push();
        fuValid_i = '0;
        fuTag_i   = '0;
        fuVal_i   = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b0;
        flush_i = 1'b0;
        completionReady_i = 1'b1;
        clear_push();

        // Reset state
        #2;
        check_val("rst_valid", completionValid_o, 0);
        check_val("rst_tag", completionRSROBTag_o, 0);
        check_val("rst_val", completionRSROBval_o, 0);
        check_val("rst_bad", badTag_o, 0);
        check_val("rst_ready", fuReady_o, 4'b1111);
        check_val("rst_busy", busy_o, 0);
        #10 reset_i = 1'b1;

        // Single push: unit 2, tag 5, value 0x1234
        set_push(2, 6'd5, 65'h1234);
        tick();
        clear_push();
        check_val("sp_valid_e1", completionValid_o, 0);
        check_val("sp_busy_e1", busy_o, 1);
        tick();
        check_val("sp_valid_e2", completionValid_o, 1);
        check_val("sp_tag_e2", completionRSROBTag_o, 5);
        check_val("sp_val_e2", completionRSROBval_o, 65'h1234);
        tick();
        check_val("sp_valid_e3", completionValid_o, 0);
        check_val("sp_busy_e3", busy_o, 0);
        check_val("sp_tag_e3", completionRSROBTag_o, 0);

        // Flush to bring the round-robin pointer back to 0
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;

        // Round-robin: four units push tags 1..4 on one edge
        for (int u = 0; u < 4; u++) set_push(u, 6'(u + 1), 65'(256 + u));
        tick();
        clear_push();
        for (int b = 0; b < 4; b++) begin
            tick();
            check_val("rr_valid", completionValid_o, 1);
            check_val("rr_tag", completionRSROBTag_o, b + 1);
            check_val("rr_val", completionRSROBval_o, 256 + b);
        end
        tick();
        check_val("rr_idle", completionValid_o, 0);
        // Pointer back at 0: unit 0 must beat unit 1
        set_push(1, 6'd7, 65'h7);
        set_push(0, 6'd6, 65'h6);
        tick();
        clear_push();
        tick();
        check_val("rr_wrap_first", completionRSROBTag_o, 6);
        tick();
        check_val("rr_wrap_second", completionRSROBTag_o, 7);
        tick();
        check_val("rr_wrap_idle", completionValid_o, 0);

        // Backpressure: stall a unit-3 beat, then fill unit 0
        completionReady_i = 1'b0;
        set_push(3, 6'd20, 65'h1_0000_0000_0000_0020);
        tick();
        clear_push();
        tick();
        check_val("bp_stall_valid", completionValid_o, 1);
        check_val("bp_stall_tag", completionRSROBTag_o, 20);
        check_val("bp_stall_val", completionRSROBval_o, 65'h1_0000_0000_0000_0020);
        set_push(0, 6'd10, 65'ha);
        tick();
        check_val("bp_ready_after1", fuReady_o, 4'b1111);
        set_push(0, 6'd11, 65'hb);
        tick();
        check_val("bp_ready_after2", fuReady_o, 4'b1110);
        check_val("bp_hold_tag2", completionRSROBTag_o, 20);
        set_push(0, 6'd12, 65'hc);
        tick();
        clear_push();
        check_val("bp_ready_after3", fuReady_o, 4'b1110);
        check_val("bp_hold_valid3", completionValid_o, 1);
        check_val("bp_hold_tag3", completionRSROBTag_o, 20);
        check_val("bp_hold_val3", completionRSROBval_o, 65'h1_0000_0000_0000_0020);
        completionReady_i = 1'b1;
        tick();
        check_val("bp_beat_10", completionRSROBTag_o, 10);
        check_val("bp_ready_drain", fuReady_o, 4'b1111);
        tick();
        check_val("bp_beat_11", completionRSROBTag_o, 11);
        tick();
        check_val("bp_no_12_valid", completionValid_o, 0);
        check_val("bp_no_12_busy", busy_o, 0);

        // Flush with units 1 and 3 buffered and a push in the flush cycle
        completionReady_i = 1'b0;
        set_push(1, 6'd21, 65'h21);
        set_push(3, 6'd23, 65'h23);
        tick();
        set_push(1, 6'd22, 65'h22);
        set_push(3, 6'd24, 65'h24);
        tick();
        clear_push();
        check_val("fl_pre_tag", completionRSROBTag_o, 21);
        check_val("fl_pre_ready", fuReady_o, 4'b0111);
        flush_i = 1'b1;
        set_push(2, 6'd25, 65'h25);
        tick();
        flush_i = 1'b0;
        clear_push();
        check_val("fl_valid", completionValid_o, 0);
        check_val("fl_tag", completionRSROBTag_o, 0);
        check_val("fl_busy", busy_o, 0);
        check_val("fl_ready", fuReady_o, 4'b1111);
        completionReady_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("fl_quiet", completionValid_o, 0);
        end

        // Bad tag
        set_push(1, 6'd0, 65'hdead);
        tick();
        clear_push();
        check_val("bt_bad", badTag_o, 1);
        check_val("bt_busy", busy_o, 0);
        tick();
        check_val("bt_no_beat", completionValid_o, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_val("bt_sticky_flush", badTag_o, 1);

        // Asynchronous reset mid-operation with two beats queued
        completionReady_i = 1'b0;
        set_push(0, 6'd30, 65'h30);
        set_push(2, 6'd32, 65'h32);
        tick();
        clear_push();
        tick();
        check_val("ar_pre_tag", completionRSROBTag_o, 30);
        check_val("ar_pre_busy", busy_o, 1);
        #3 reset_i = 1'b0;
        #1;
        check_val("ar_valid", completionValid_o, 0);
        check_val("ar_tag", completionRSROBTag_o, 0);
        check_val("ar_val", completionRSROBval_o, 0);
        check_val("ar_busy", busy_o, 0);
        check_val("ar_bad", badTag_o, 0);
        check_val("ar_ready", fuReady_o, 4'b1111);
        #2 reset_i = 1'b1;
        completionReady_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("ar_quiet_valid", completionValid_o, 0);
            check_val("ar_quiet_busy", busy_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/completion_arbiter.md
COMPLETION_ARBITER -- requirements
Module: completion_arbiter

Interface
REQ-001 SHALL have parameter ROBsize, default 32, ROB entry count.
REQ-002 SHALL have parameter ROBsizeLog, default $clog2(ROBsize+1), tag width; tag 0 means "no ROB entry".
REQ-003 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have flush_i  input  1  synchronous flush on branch mispredict.
REQ-006 SHALL have fuValid_i  input  [3:0]  functional unit i presents a result.
REQ-007 SHALL have fuTag_i  input  [3:0][ROBsizeLog-1:0]  ROB tag of the result from unit i.
REQ-008 SHALL have fuVal_i  input  [3:0][64:0]  result from unit i; bit 64 is the condition/flag bit, bits 63:0 are data.
REQ-009 SHALL have fuReady_o  output  [3:0]  unit i's FIFO can accept a push.
REQ-010 SHALL have completionReady_i  input  1  ROB/completion stage accepts the current bus beat.
REQ-011 SHALL have completionValid_o  output  1  bus beat valid.
REQ-012 SHALL have completionRSROBTag_o  output  [ROBsizeLog-1:0]  broadcast tag.
REQ-013 SHALL have completionRSROBval_o  output  [64:0]  broadcast value.
REQ-014 SHALL have badTag_o  output  1  sticky error: a push with tag 0 was seen.
REQ-015 SHALL have busy_o  output  1  any FIFO non-empty or completionValid_o high.

Function
REQ-016 SHALL hold one 2-entry FIFO per unit, each entry storing {tag, value}, with a count in 0..2.
REQ-017 SHALL drive fuReady_o[i] = (count[i] < 2) from registered count only, independent of a same-cycle pop.
REQ-018 SHALL push into FIFO i on an edge where fuValid_i[i] & fuReady_o[i] & ~flush_i & (fuTag_i[i] != 0).
REQ-019 SHALL drop a push with fuTag_i[i]==0 and set badTag_o, which stays set until reset.
REQ-020 SHALL treat the output register as advancing when ~completionValid_o | completionReady_i.
REQ-021 SHALL pick the winner, when the output advances, as the first non-empty FIFO searching rrPtr, rrPtr+1, ... mod 4.
REQ-022 SHALL, on advance with a winner w: pop FIFO w's head into the output register, set completionValid_o=1, and set rrPtr=(w+1) mod 4.
REQ-023 SHALL, on advance with no winner: set completionValid_o=0 and tag/value to 0, with rrPtr unchanged.
REQ-024 SHALL, when completionValid_o & ~completionReady_i, hold tag, value and valid stable with no pop.
REQ-025 SHALL allow a push and a pop of the same FIFO on one edge; the count is then unchanged and order is preserved.
REQ-026 SHALL see a push made on edge E in arbitration from edge E+1; minimum latency is 2 edges (push to output valid).
REQ-027 SHALL preserve per-unit FIFO order; each accepted push appears on the bus exactly once unless flushed.
REQ-028 SHALL, on flush_i high at an edge (priority over all else): clear all counts, set completionValid_o=0, tag/value=0, rrPtr=0, and drop that edge's pushes; badTag_o is unaffected.
REQ-029 SHALL drive completionRSROBTag_o=0 whenever completionValid_o=0.

Reset
REQ-030 SHALL, while reset_i is low, immediately force: all counts 0, rrPtr=0, completionValid_o=0, tag=0, value=0, badTag_o=0, fuReady_o=4'b1111, busy_o=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all buffered results; the first edge after release behaves as after power-up.

Verification
REQ-032 SHALL verify single push: unit 2 pushes tag 5, value 0x1234 at edge 1 -> bus valid after edge 2 with tag 5, value 0x1234; busy_o low after edge 3.
REQ-033 SHALL verify round-robin: all four units push tags 1..4 on one edge with rrPtr=0 -> bus shows tags 1,2,3,4 on consecutive beats; rrPtr ends at 0.
REQ-034 SHALL verify backpressure: unit 0 pushes 3 results with completionReady_i=0 -> fuReady_o[0] drops after the 2nd push, the 3rd is not accepted, and the bus holds the first beat stable until ready returns.
REQ-035 SHALL verify flush: 2 entries buffered in units 1 and 3 plus a push in the flush cycle -> after the flush edge completionValid_o=0, busy_o=0, and no buffered tag ever appears.
REQ-036 SHALL verify bad tag: unit 1 pushes tag 0 -> nothing is enqueued, badTag_o=1 and stays 1 through a flush, clearing only on reset.
REQ-037 SHALL verify async reset: reset_i falls between edges with 2 beats queued -> outputs clear without waiting for a clock edge, and nothing is emitted after release.
